// File: rtl/llc_rst_flush_seq_pkg.sv
// Shared cache types and constants for the LLC reset/flush sequencer.
package llc_rst_flush_seq_pkg;

    typedef logic [1:0] llc_state_t;
    typedef logic       hprot_t;

    localparam llc_state_t INVALID   = 2'd0;
    localparam llc_state_t VALID     = 2'd1;
    localparam llc_state_t SHARED    = 2'd2;
    localparam llc_state_t EXCLUSIVE = 2'd3;

    localparam hprot_t INSTR = 1'b0;
    localparam hprot_t DATA  = 1'b1;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_READ,
        SEQ_CHECK,
        SEQ_WB,
        SEQ_UPDATE,
        SEQ_DONE
    } llc_seq_state_t;

endpackage

// File: rtl/llc_rst_flush_seq_way_prio_enc.sv
// Lowest-set-bit priority encoder over the per-way pending mask.
module llc_way_prio_enc #(
    parameter int WAYS = 8
) (
    input  logic [WAYS-1:0]         i_vec,
    output logic [$clog2(WAYS)-1:0] o_idx,
    output logic                    o_any
);

    localparam int WW = $clog2(WAYS);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (i_vec[w]) begin
                o_idx = w[WW-1:0];
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/llc_rst_flush_seq.sv
// LLC reset/flush set-walking sequencer.
// Optional feature macro: LLC_FLUSH_DIRTY_ONLY_EN (flush writes back only dirty ways).
//
// state      | meaning
// SEQ_IDLE   | waiting for start_rst / start_flush
// SEQ_READ   | rd_en pulse for the current set
// SEQ_CHECK  | way buffers valid; latch pending write-back mask
// SEQ_WB     | present lowest pending way until wb_ready
// SEQ_UPDATE | update_en pulse for the current set
// SEQ_DONE   | done pulse, counter back to 0
module llc_rst_flush_seq
    import llc_rst_flush_seq_pkg::*;
#(
    parameter int SETS = 256,
    parameter int WAYS = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_rst,
    input  logic                       start_flush,
    output logic                       busy,
    output logic                       done,
    output logic                       rd_en,
    output logic [$clog2(SETS)-1:0]    set_idx,
    input  llc_state_t [WAYS-1:0]      states_buf,
    input  hprot_t     [WAYS-1:0]      hprots_buf,
    input  logic       [WAYS-1:0]      dirty_bits_buf,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [$clog2(WAYS)-1:0]    wb_way,
    output logic                       update_en,
    output logic                       is_rst_to_resume,
    output logic                       is_flush_to_resume
);

    localparam int SW = $clog2(SETS);
    localparam int WW = $clog2(WAYS);
    localparam logic [SW-1:0] LAST_SET = SW'(SETS - 1);

    llc_seq_state_t  r_state;
    logic            r_flush_mode;
    logic [WAYS-1:0] r_mask;
    logic [SW-1:0]   r_set_idx;
    logic [WW-1:0]   r_wb_way;
    logic            r_busy, r_done, r_rd_en, r_wb_valid;
    logic            r_update_en, r_is_rst, r_is_flush;

    logic [WAYS-1:0] w_qual;
    logic [WAYS-1:0] w_clr;
    logic [WAYS-1:0] w_enc_in;
    logic [WW-1:0]   w_enc_idx;
    logic            w_enc_any;

    // Per-way write-back qualification from the freshly read way buffers.
    always_comb begin
        w_qual = '0;
        for (int w = 0; w < WAYS; w++) begin
`ifdef LLC_FLUSH_DIRTY_ONLY_EN
            w_qual[w] = (states_buf[w] == VALID) && (hprots_buf[w] == DATA) && dirty_bits_buf[w];
`else
            w_qual[w] = (states_buf[w] == VALID) && (hprots_buf[w] == DATA);
`endif
        end
    end

`ifndef LLC_FLUSH_DIRTY_ONLY_EN
    logic w_unused_dirty;
    assign w_unused_dirty = ^dirty_bits_buf;
`endif

    // Encoder sees the mask as it will be after this cycle: the new mask in
    // CHECK, or the current mask minus the accepted way in WB.
    always_comb begin
        w_clr           = '0;
        w_clr[r_wb_way] = 1'b1;
        w_enc_in        = (r_state == SEQ_CHECK) ? w_qual : (r_mask & ~w_clr);
    end

    llc_way_prio_enc #(.WAYS(WAYS)) u_prio_enc (
        .i_vec (w_enc_in),
        .o_idx (w_enc_idx),
        .o_any (w_enc_any)
    );

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= SEQ_IDLE;
            r_flush_mode <= 1'b0;
            r_mask       <= '0;
            r_set_idx    <= '0;
            r_wb_way     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_rd_en      <= 1'b0;
            r_wb_valid   <= 1'b0;
            r_update_en  <= 1'b0;
            r_is_rst     <= 1'b0;
            r_is_flush   <= 1'b0;
        end else begin
            r_rd_en     <= 1'b0;
            r_update_en <= 1'b0;
            r_is_rst    <= 1'b0;
            r_is_flush  <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                SEQ_IDLE: begin
                    if (start_rst) begin
                        r_state      <= SEQ_UPDATE;
                        r_flush_mode <= 1'b0;
                        r_set_idx    <= '0;
                        r_busy       <= 1'b1;
                        r_update_en  <= 1'b1;
                        r_is_rst     <= 1'b1;
                    end else if (start_flush) begin
                        r_state      <= SEQ_READ;
                        r_flush_mode <= 1'b1;
                        r_set_idx    <= '0;
                        r_busy       <= 1'b1;
                        r_rd_en      <= 1'b1;
                    end
                end
                SEQ_READ: r_state <= SEQ_CHECK;
                SEQ_CHECK: begin
                    r_mask <= w_qual;
                    if (w_enc_any) begin
                        r_state    <= SEQ_WB;
                        r_wb_valid <= 1'b1;
                        r_wb_way   <= w_enc_idx;
                    end else begin
                        r_state     <= SEQ_UPDATE;
                        r_update_en <= 1'b1;
                        r_is_flush  <= 1'b1;
                    end
                end
                SEQ_WB: begin
                    if (wb_ready) begin
                        r_mask <= w_enc_in;
                        if (w_enc_any) begin
                            r_wb_way <= w_enc_idx;
                        end else begin
                            r_state     <= SEQ_UPDATE;
                            r_wb_valid  <= 1'b0;
                            r_update_en <= 1'b1;
                            r_is_flush  <= 1'b1;
                        end
                    end
                end
                SEQ_UPDATE: begin
                    if (r_set_idx == LAST_SET) begin
                        r_state <= SEQ_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_set_idx <= r_set_idx + 1'b1;
                        if (r_flush_mode) begin
                            r_state <= SEQ_READ;
                            r_rd_en <= 1'b1;
                        end else begin
                            r_state     <= SEQ_UPDATE;
                            r_update_en <= 1'b1;
                            r_is_rst    <= 1'b1;
                        end
                    end
                end
                SEQ_DONE: begin
                    r_state   <= SEQ_IDLE;
                    r_busy    <= 1'b0;
                    r_set_idx <= '0;
                end
                default: r_state <= SEQ_IDLE;
            endcase
        end
    end

    assign busy               = r_busy;
    assign done               = r_done;
    assign rd_en              = r_rd_en;
    assign set_idx            = r_set_idx;
    assign wb_valid           = r_wb_valid;
    assign wb_way             = r_wb_way;
    assign update_en          = r_update_en;
    assign is_rst_to_resume   = r_is_rst;
    assign is_flush_to_resume = r_is_flush;

endmodule

// File: tb/tb_llc_rst_flush_seq.sv
// Self-checking bench for llc_rst_flush_seq (SETS=4, WAYS=8).
module tb_llc_rst_flush_seq;
    import llc_rst_flush_seq_pkg::*;

    localparam int SETS = 4;
    localparam int WAYS = 8;
`ifdef LLC_FLUSH_DIRTY_ONLY_EN
    localparam bit DIRTY_ONLY = 1'b1;
`else
    localparam bit DIRTY_ONLY = 1'b0;
`endif

    logic clk, rst, start_rst, start_flush, wb_ready;
    logic busy, done, rd_en, wb_valid, update_en, is_rst_to_resume, is_flush_to_resume;
    logic [$clog2(SETS)-1:0] set_idx;
    logic [$clog2(WAYS)-1:0] wb_way;
    llc_state_t [WAYS-1:0] states_buf;
    hprot_t     [WAYS-1:0] hprots_buf;
    logic       [WAYS-1:0] dirty_bits_buf;

    llc_rst_flush_seq #(.SETS(SETS), .WAYS(WAYS)) dut (
        .clk(clk), .rst(rst), .start_rst(start_rst), .start_flush(start_flush),
        .busy(busy), .done(done), .rd_en(rd_en), .set_idx(set_idx),
        .states_buf(states_buf), .hprots_buf(hprots_buf), .dirty_bits_buf(dirty_bits_buf),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_way(wb_way),
        .update_en(update_en), .is_rst_to_resume(is_rst_to_resume),
        .is_flush_to_resume(is_flush_to_resume)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cache contents model.
    llc_state_t m_st [SETS][WAYS];
    hprot_t     m_hp [SETS][WAYS];
    logic       m_d  [SETS][WAYS];

    typedef struct {
        bit is_wb;
        int set;
        int way;
    } evt_t;
    evt_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input longint obs, input longint expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic bit qual(llc_state_t st, hprot_t hp, logic d);
        return (st == VALID) && (hp == DATA) && (d || !DIRTY_ONLY);
    endfunction

    // Random contents with no qualifying way anywhere.
    task automatic clear_mem();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_st[s][w] = llc_state_t'($urandom_range(3));
                m_hp[s][w] = (m_st[s][w] == VALID) ? INSTR : hprot_t'($urandom_range(1));
                m_d[s][w]  = 1'($urandom_range(1));
            end
    endtask

    task automatic set_way(input int s, input int w, input logic d);
        m_st[s][w] = VALID;
        m_hp[s][w] = DATA;
        m_d[s][w]  = d;
    endtask

    task automatic fill_random();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_st[s][w] = llc_state_t'($urandom_range(3));
                m_hp[s][w] = hprot_t'($urandom_range(1));
                m_d[s][w]  = 1'($urandom_range(1));
            end
    endtask

    // One complete walk checked against the expected event list.
    task automatic run_walk(input bit do_flush, input bit both_start, input int first_stall,
                            input int stall_pct, input bit mid_start, input bit abort_wb);
        int  cyc, wb_cyc, stalls, prev_way;
        bit  was_stall, seen_done, ready;
        evt_t e;
        exp_q.delete();
        for (int s = 0; s < SETS; s++) begin
            if (do_flush)
                for (int w = 0; w < WAYS; w++)
                    if (qual(m_st[s][w], m_hp[s][w], m_d[s][w])) exp_q.push_back('{1'b1, s, w});
            exp_q.push_back('{1'b0, s, 0});
        end
        @(negedge clk);
        start_rst   = !do_flush;
        start_flush = do_flush || both_start;
        @(negedge clk);
        start_rst   = 1'b0;
        start_flush = 1'b0;
        check_eq("busy_rise", busy, 1);
        cyc = 0; wb_cyc = 0; stalls = 0; prev_way = 0;
        was_stall = 1'b0; seen_done = 1'b0;
        for (int n = 0; n < 4000 && !seen_done; n++) begin
            if (busy) cyc++;
            start_flush = mid_start && (n == 3);
            if (was_stall) begin
                check_eq("wb_hold_valid", wb_valid, 1);
                check_eq("wb_hold_way", wb_way, prev_way);
            end
            if (rd_en) begin
                check_eq("rd_evt_avail", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check_eq("rd_set", set_idx, exp_q[0].set);
                for (int w = 0; w < WAYS; w++) begin
                    states_buf[w]     = m_st[set_idx][w];
                    hprots_buf[w]     = m_hp[set_idx][w];
                    dirty_bits_buf[w] = m_d[set_idx][w];
                end
            end
            if (update_en) begin
                check_eq("upd_evt_avail", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq("upd_kind", 0, e.is_wb);
                    check_eq("upd_set", set_idx, e.set);
                    check_eq("upd_is_rst", is_rst_to_resume, !do_flush);
                    check_eq("upd_is_flush", is_flush_to_resume, do_flush);
                end
            end
            if (wb_valid) begin
                wb_cyc++;
                if (abort_wb) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    wb_ready = 1'b0;
                    check_eq("abort_ctrl", {busy, done, rd_en, wb_valid, update_en,
                                            is_rst_to_resume, is_flush_to_resume}, 0);
                    check_eq("abort_idx", {set_idx, wb_way}, 0);
                    @(negedge clk);
                    check_eq("abort_idle", {busy, done}, 0);
                    return;
                end
                ready = (stalls < first_stall) ? 1'b0 : ($urandom_range(99) >= stall_pct);
                if (!ready) stalls++;
                wb_ready = ready;
                if (ready) begin
                    check_eq("wb_evt_avail", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check_eq("wb_kind", 1, e.is_wb);
                        check_eq("wb_set", set_idx, e.set);
                        check_eq("wb_way", wb_way, e.way);
                    end
                end
                was_stall = !ready;
                prev_way  = wb_way;
            end else begin
                wb_ready  = 1'($urandom_range(1));
                was_stall = 1'b0;
            end
            if (done) begin
                seen_done = 1'b1;
                check_eq("done_q_empty", exp_q.size(), 0);
                check_eq("walk_cycles", cyc, do_flush ? (3 * SETS + wb_cyc + 1) : (SETS + 1));
            end
            @(negedge clk);
        end
        start_flush = 1'b0;
        check_eq("done_seen", seen_done, 1);
        check_eq("idle_after_done", {busy, done}, 0);
        @(negedge clk);
        check_eq("no_restart", busy, 0);
    endtask

    initial begin
        rst = 1'b1; start_rst = 1'b0; start_flush = 1'b0; wb_ready = 1'b0;
        states_buf = '0; hprots_buf = '0; dirty_bits_buf = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_ctrl", {busy, done, rd_en, wb_valid, update_en,
                                is_rst_to_resume, is_flush_to_resume}, 0);
        check_eq("reset_idx", {set_idx, wb_way}, 0);
        rst = 1'b0;

        // Reset walk.
        clear_mem();
        run_walk(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

        // Single write-back: set 2 way 5, always ready.
        clear_mem();
        set_way(2, 5, 1'b1);
        run_walk(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);

        // Set 0 ways 1 and 6, first handshake stalled 3 cycles.
        clear_mem();
        set_way(0, 1, 1'b1);
        set_way(0, 6, 1'b1);
        run_walk(1'b1, 1'b0, 3, 0, 1'b0, 1'b0);

        // Only VALID DATA way has its dirty bit clear.
        clear_mem();
        set_way(1, 3, 1'b0);
        run_walk(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);

        // Both starts together, plus a flush pulse while busy.
        clear_mem();
        set_way(1, 2, 1'b1);
        run_walk(1'b0, 1'b1, 0, 0, 1'b1, 1'b0);
        run_walk(1'b1, 1'b0, 0, 30, 1'b1, 1'b0);

        // rst during WB, then restart.
        clear_mem();
        set_way(1, 2, 1'b1);
        set_way(3, 7, 1'b1);
        run_walk(1'b1, 1'b0, 5, 0, 1'b0, 1'b1);
        run_walk(1'b1, 1'b0, 0, 40, 1'b0, 1'b0);

        // Randomized flush contents and back-pressure.
        for (int k = 0; k < 8; k++) begin
            fill_random();
            run_walk(1'b1, 1'b0, 0, $urandom_range(60), 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/llc_rst_flush_seq.md
# llc_rst_flush_seq

Set-walking sequencer for the LLC reset and flush operations. On a reset or flush request it steps the set index from 0 to SETS-1. For a flush, it reads each set, issues one write-back per qualifying way over a valid/ready handshake, and then fires one update-stage cycle. For a reset, it fires the update-stage cycle only. It sits between the LLC top-level request arbitration and the llc_update stage, and it owns the set counter used for reset/flush.

## Interface
Parameters:
- SETS, 256: number of LLC sets; must be a power of 2, ≥ 2
- WAYS, 8: number of LLC ways; must be a power of 2, ≥ 2

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start_rst  in  1  pulse: begin the reset walk
- start_flush  in  1  pulse: begin the flush walk
- busy  out  1  high from acceptance until done
- done  out  1  one-cycle pulse after the last set is updated
- rd_en  out  1  request a read of set `set_idx` into the way buffers
- set_idx  out  $clog2(SETS)  current set
- states_buf  in  WAYS×llc_state_t  state per way; valid the cycle after rd_en
- hprots_buf  in  WAYS×hprot_t  hprot per way; same timing as states_buf
- dirty_bits_buf  in  WAYS×1  dirty bit per way; same timing as states_buf
- wb_valid  out  1  write-back request for (set_idx, wb_way)
- wb_ready  in  1  memory-side accept
- wb_way  out  $clog2(WAYS)  way being written back
- update_en  out  1  one-cycle pulse to llc_update
- is_rst_to_resume  out  1  qualifies update_en during a reset walk
- is_flush_to_resume  out  1  qualifies update_en during a flush walk

## Operation
- States: IDLE, READ, CHECK, WB, UPDATE, DONE.
- IDLE:
  - start_rst → UPDATE in reset mode, set_idx=0.
  - else start_flush → READ in flush mode, set_idx=0.
  - Both high in the same cycle: reset wins; the flush is dropped.
  - Starts are ignored while busy.
- READ: rd_en=1 for one cycle → CHECK.
- CHECK: latch the pending mask. A way's bit is set when states_buf[w]==VALID and hprots_buf[w]==DATA (dirty qualifier: see Configuration).
  - Mask nonzero → WB.
  - Mask zero → UPDATE.
- WB:
  - wb_way = index of the lowest set bit in the mask; wb_valid=1.
  - wb_valid and wb_way stay stable until wb_ready.
  - On wb_valid&&wb_ready, clear that bit. If the mask becomes zero → UPDATE; otherwise stay in WB, next way presented the following cycle.
- UPDATE:
  - update_en=1 for one cycle, with is_rst_to_resume or is_flush_to_resume set per mode.
  - If set_idx==SETS-1 → DONE. Otherwise set_idx+1 → UPDATE (reset mode) or READ (flush mode).
- DONE: done=1 for one cycle, set_idx returns to 0 → IDLE.
- Mode flag is latched at start and held for the whole walk.

## Timing
- Reset values: every output 0, set_idx=0, mask=0, state IDLE.
- rst asserted in any state returns the block to IDLE next cycle. An in-flight wb_valid drops without completion, and no done pulse is produced.
- Registered (Moore) outputs. busy=1 in every state except IDLE; busy rises the cycle after start.
- Reset walk: one update_en per cycle; SETS+1 cycles from the first busy cycle to done (SETS UPDATE cycles + DONE).
- Flush walk, per set:
  - 3 cycles when the mask is zero (READ, CHECK, UPDATE).
  - Otherwise 3 + Σ(cycles each way waits for wb_ready, minimum 1 per way).
- set_idx is constant from READ through UPDATE of a set. The counter never wraps mid-walk; the last set is SETS-1.

## Configuration
- LLC_FLUSH_DIRTY_ONLY_EN:
  - Defined: a way qualifies for write-back only when additionally dirty_bits_buf[w]==1.
  - Undefined: every VALID DATA way is written back regardless of dirty bit.
  - Reset mode is unaffected either way.

## Structure
- llc_state_t, hprot_t, VALID, DATA, and a new llc_seq_state_t enum belong in the shared cache types/constants package.
- One sub-module: llc_way_prio_enc (lowest-set-bit priority encoder over WAYS bits; outputs index and any-set).

## Test plan
- Reset walk, SETS=4: pulse start_rst → update_en with is_rst_to_resume on 4 consecutive cycles, set_idx 0,1,2,3; done 1 cycle later; wb_valid never rises.
- Flush, one VALID DATA way (way 5 of set 2), wb_ready tied 1 → exactly one wb_valid, with set_idx=2, wb_way=5; all 4 sets updated; done.
- Flush, set 0 ways 1 and 6 qualify, wb_ready low for 3 cycles:
  - wb_valid/wb_way=1 held stable throughout the stall;
  - way 6 is presented the cycle after acceptance;
  - update_en follows.
- Dirty bit clear on the only VALID DATA way (way 3):
  - With LLC_FLUSH_DIRTY_ONLY_EN: no write-back.
  - Without it: one write-back, wb_way=3.
- start_rst and start_flush asserted in the same cycle → reset walk only; a start_flush pulse during busy is ignored.
- rst asserted while in WB → next cycle all outputs are 0 and the state is IDLE; a later start_flush restarts the walk from set 0.
